// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_countdown_timer
//  Description : Multi-digit BCD down-counter with run/pause control, sticky
//                and pulsed timeout, low-time warning and optional auto-reload.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_countdown_timer #(
   parameter int NUM_DIGITS  = 4,
   parameter int MAX_DIGIT   = 9,
   parameter int WARN_LEVEL  = 10,
   parameter int AUTO_RELOAD = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   input  logic                    enable,
   input  logic                    tick,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic                    running,
   output logic                    timeout,
   output logic                    timeout_pulse,
   output logic                    warn
);

   localparam int          c_W    = 4 * NUM_DIGITS;
   localparam logic [3:0]  c_MAX  = 4'(MAX_DIGIT);
   localparam logic [31:0] c_WARN = 32'(WARN_LEVEL);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      PAUSE   = 2'd2,
      EXPIRED = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [c_W-1:0]   digits_q, digits_d;
   logic [c_W-1:0]   reload_q, reload_d;
   logic             running_q, timeout_q, pulse_q, warn_q;

   logic [c_W-1:0]   clamped;
   logic [c_W-1:0]   decremented;
   logic             borrow;
   logic [31:0]      next_value;
   logic             warn_d;

   // Integer interpretation of a packed BCD word, digits weighted by 10^i.
   function automatic logic [31:0] bcd_value(input logic [c_W-1:0] d);
      logic [31:0] acc;
      acc = 32'd0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         acc = acc * 32'd10 + {28'd0, d[4*i +: 4]};
      end
      return acc;
   endfunction

   // Saturate each incoming digit to the largest legal digit value.
   generate
      for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_clamp
         assign clamped[4*g +: 4] = (load_value[4*g +: 4] > c_MAX) ? c_MAX
                                                                   : load_value[4*g +: 4];
      end
   endgenerate

   // Single-cycle BCD subtract-by-one: zero digits wrap to MAX and pass the borrow up.
   always_comb begin
      decremented = digits_q;
      borrow      = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (borrow) begin
            if (digits_q[4*i +: 4] == 4'd0) begin
               decremented[4*i +: 4] = c_MAX;
            end else begin
               decremented[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
               borrow                = 1'b0;
            end
         end
      end
   end

   // Next-state selection: load beats every enable/tick transition.
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      reload_d = reload_q;
      if (load) begin
         digits_d = clamped;
         reload_d = clamped;
         if (clamped == '0) begin
            state_d = EXPIRED;
         end else if (enable) begin
            state_d = RUN;
         end else begin
            state_d = PAUSE;
         end
      end else begin
         case (state_q)
            RUN: begin
               if (!enable) begin
                  state_d = PAUSE;
               end else if (tick) begin
                  if (digits_q == c_W'(1)) begin
                     digits_d = '0;
                     state_d  = EXPIRED;
                  end else begin
                     digits_d = decremented;
                  end
               end
            end
            PAUSE: begin
               if (enable) begin
                  state_d = RUN;
               end
            end
            EXPIRED: begin
               if ((AUTO_RELOAD != 0) && enable && tick && (reload_q != '0)) begin
                  digits_d = reload_q;
                  state_d  = RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // Warning is derived from the value being registered this edge.
   always_comb begin
      next_value = bcd_value(digits_d);
      warn_d     = ((state_d == RUN) || (state_d == PAUSE)) &&
                   (next_value != 32'd0) && (next_value <= c_WARN);
   end

   // State, value and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         digits_q  <= '0;
         reload_q  <= '0;
         running_q <= 1'b0;
         timeout_q <= 1'b0;
         pulse_q   <= 1'b0;
         warn_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         reload_q  <= reload_d;
         running_q <= (state_d == RUN);
         timeout_q <= (state_d == EXPIRED);
         pulse_q   <= (state_d == EXPIRED) && (state_q != EXPIRED);
         warn_q    <= warn_d;
      end
   end

   assign digits_out    = digits_q;
   assign running       = running_q;
   assign timeout       = timeout_q;
   assign timeout_pulse = pulse_q;
   assign warn          = warn_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_countdown_timer
//  Description : Directed bench for bcd_countdown_timer; one instance without
//                and one with auto-reload, checked through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_countdown_timer;

   logic        clk = 1'b0;
   logic        rst0, rst1;
   logic        load, enable, tick;
   logic [15:0] load_value;

   logic [15:0] dig0, dig1;
   logic        run0, run1, to0, to1, tp0, tp1, wn0, wn1;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      bit          which;
      logic [19:0] exp;
   } sb_t;

   sb_t sb_q[$];

   always #5 clk = ~clk;

   bcd_countdown_timer #(.NUM_DIGITS(4), .MAX_DIGIT(9), .WARN_LEVEL(10), .AUTO_RELOAD(0)) dut0 (
      .clk(clk), .rst(rst0), .load(load), .load_value(load_value), .enable(enable),
      .tick(tick), .digits_out(dig0), .running(run0), .timeout(to0),
      .timeout_pulse(tp0), .warn(wn0)
   );

   bcd_countdown_timer #(.NUM_DIGITS(4), .MAX_DIGIT(9), .WARN_LEVEL(10), .AUTO_RELOAD(1)) dut1 (
      .clk(clk), .rst(rst1), .load(load), .load_value(load_value), .enable(enable),
      .tick(tick), .digits_out(dig1), .running(run1), .timeout(to1),
      .timeout_pulse(tp1), .warn(wn1)
   );

   function automatic logic [19:0] ex(input logic [15:0] d, input logic r, input logic t,
                                      input logic p, input logic w);
      return {d, r, t, p, w};
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      int          x;
      x = v;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x           = x / 10;
      end
      return r;
   endfunction

   // Drive one cycle of stimulus, queue its expected result, compare after the edge.
   task automatic step(input string tag, input bit which, input logic ld,
                       input logic [15:0] lv, input logic en, input logic tk,
                       input logic [19:0] exp);
      sb_t         e;
      logic [19:0] obs;
      load       = ld;
      load_value = lv;
      enable     = en;
      tick       = tk;
      sb_q.push_back('{tag, which, exp});
      @(posedge clk);
      #1;
      e   = sb_q.pop_front();
      obs = e.which ? {dig1, run1, to1, tp1, wn1} : {dig0, run0, to0, tp0, wn0};
      checks++;
      assert (obs === e.exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h (digits,run,to,pulse,warn)", e.tag, obs, e.exp);
      end
   endtask

   initial begin
      rst0 = 1'b1;
      rst1 = 1'b1;
      load = 1'b0; load_value = '0; enable = 1'b0; tick = 1'b0;

      step("reset_state", 0, 0, 16'h0000, 0, 0, ex(16'h0000, 0, 0, 0, 0));
      rst0 = 1'b0;

      // Reset in the middle of a run
      step("load_0042",  0, 1, 16'h0042, 1, 0, ex(16'h0042, 1, 0, 0, 0));
      rst0 = 1'b1;
      step("rst_midrun", 0, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 0, 0, 0));
      rst0 = 1'b0;

      // Digit clamping on load
      step("clamp_0A0C", 0, 1, 16'h0A0C, 1, 0, ex(16'h0909, 1, 0, 0, 0));
      step("dec_0909",   0, 0, 16'h0000, 1, 1, ex(16'h0908, 1, 0, 0, 0));

      // Borrow across several digits
      step("load_0100",  0, 1, 16'h0100, 1, 0, ex(16'h0100, 1, 0, 0, 0));
      step("borrow_0099",0, 0, 16'h0000, 1, 1, ex(16'h0099, 1, 0, 0, 0));

      // Long countdown from 1000 into the warning band
      step("load_1000",  0, 1, 16'h1000, 1, 0, ex(16'h1000, 1, 0, 0, 0));
      step("borrow_0999",0, 0, 16'h0000, 1, 1, ex(16'h0999, 1, 0, 0, 0));
      for (int cnt = 998; cnt >= 10; cnt--) begin
         step("countdown", 0, 0, 16'h0000, 1, 1, ex(to_bcd(cnt), 1, 0, 0, (cnt <= 10)));
      end

      // Pause: enable drop with a tick in the same cycle
      step("pause_drop",  0, 0, 16'h0000, 0, 1, ex(16'h0010, 0, 0, 0, 1));
      step("pause_tick",  0, 0, 16'h0000, 0, 1, ex(16'h0010, 0, 0, 0, 1));
      step("resume_tick", 0, 0, 16'h0000, 1, 1, ex(16'h0010, 1, 0, 0, 1));
      step("run_0009",    0, 0, 16'h0000, 1, 1, ex(16'h0009, 1, 0, 0, 1));

      // Load of zero with a simultaneous tick
      step("load0_tick",  0, 1, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 1, 0));
      step("exp_sticky",  0, 0, 16'h0000, 1, 0, ex(16'h0000, 0, 1, 0, 0));
      step("load0_inexp", 0, 1, 16'h0000, 1, 0, ex(16'h0000, 0, 1, 0, 0));

      // Load while paused stays paused
      step("load_pause",  0, 1, 16'h0005, 0, 1, ex(16'h0005, 0, 0, 0, 1));
      step("pause_hold",  0, 0, 16'h0000, 0, 1, ex(16'h0005, 0, 0, 0, 1));

      // Expiry from 0002
      step("load_0002",   0, 1, 16'h0002, 1, 0, ex(16'h0002, 1, 0, 0, 1));
      step("tick_0001",   0, 0, 16'h0000, 1, 1, ex(16'h0001, 1, 0, 0, 1));
      step("tick_expire", 0, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 1, 0));
      step("exp_ignore1", 0, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 0, 0));
      step("exp_ignore2", 0, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 0, 0));

      // Auto-reload instance
      rst1 = 1'b0;
      step("ar_load_0003", 1, 1, 16'h0003, 1, 0, ex(16'h0003, 1, 0, 0, 1));
      step("ar_0002",      1, 0, 16'h0000, 1, 1, ex(16'h0002, 1, 0, 0, 1));
      step("ar_0001",      1, 0, 16'h0000, 1, 1, ex(16'h0001, 1, 0, 0, 1));
      step("ar_expire1",   1, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 1, 0));
      step("ar_exp_pause", 1, 0, 16'h0000, 0, 1, ex(16'h0000, 0, 1, 0, 0));
      step("ar_reload",    1, 0, 16'h0000, 1, 1, ex(16'h0003, 1, 0, 0, 1));
      step("ar_r0002",     1, 0, 16'h0000, 1, 1, ex(16'h0002, 1, 0, 0, 1));
      step("ar_r0001",     1, 0, 16'h0000, 1, 1, ex(16'h0001, 1, 0, 0, 1));
      step("ar_expire2",   1, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 1, 0));
      step("ar_load0",     1, 1, 16'h0000, 1, 0, ex(16'h0000, 0, 1, 0, 0));
      step("ar_reload0",   1, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 0, 0));
      step("ar_reload0b",  1, 0, 16'h0000, 1, 1, ex(16'h0000, 0, 1, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD down-counter. Replaces per-digit instances chained by borrow wires with one block.
- Holds NUM_DIGITS decimal digits with an internal borrow chain, a run/pause control, sticky and pulsed timeout outputs, a low-time warning flag and optional auto-reload.
- Sits between the game controller, which loads and starts rounds, and the display driver and round-end logic.

Parameters:
- NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
- MAX_DIGIT, 9, largest legal digit value (1..9); also the value a digit wraps to on borrow.
- WARN_LEVEL, 10, integer threshold; warn asserts while counter value (as an integer) is less than or equal to WARN_LEVEL and greater than 0.
- AUTO_RELOAD, 0, 1 = on a tick while EXPIRED, reload the last loaded value and resume counting.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  capture load_value this cycle.
- load_value  in  4*NUM_DIGITS  packed BCD, digit i at bits [4i+3:4i].
- enable  in  1  1 = run, 0 = pause (level).
- tick  in  1  one-cycle decrement strobe (e.g. 1 Hz enable).
- digits_out  out  4*NUM_DIGITS  current packed BCD value.
- running  out  1  state == RUN.
- timeout  out  1  sticky, state == EXPIRED.
- timeout_pulse  out  1  one cycle, on entry to EXPIRED.
- warn  out  1  low-time indication.

Behaviour:
- Reset: the synchronous, active-high rst on clk overrides everything.
  - digits_out=0, reload register=0, state=IDLE.
  - running=0, timeout=0, timeout_pulse=0, warn=0.
- Load clamp: each digit of load_value greater than MAX_DIGIT is clamped to MAX_DIGIT when stored. The same clamped value is written to digits_out and to the reload register.
- States and transitions:
  - IDLE: no counting. load with nonzero clamped value goes to RUN if enable=1, else PAUSE. load with value 0 goes to EXPIRED.
  - RUN: a tick with value greater than 1 decrements by 1. A tick with value equal to 1 writes 0 and goes to EXPIRED. enable=0 goes to PAUSE on the next edge, and a tick in that same cycle is ignored.
  - PAUSE: value held and ticks ignored. enable=1 goes to RUN.
  - EXPIRED: digits_out=0 and timeout=1.
    - AUTO_RELOAD=0: ticks ignored.
    - AUTO_RELOAD=1 and enable=1: a tick writes the reload register to digits_out and goes to RUN. If the reload register is 0, the state stays EXPIRED and no new timeout_pulse is produced.
- load from any state: load is accepted in every state and has priority over tick and enable in the same cycle. The tick is dropped. The next state follows the IDLE rules above.
- Decrement arithmetic: a single-cycle BCD subtract across all digits.
  - Digit 0 is decremented. Any digit that is 0 and receives a borrow becomes MAX_DIGIT and propagates the borrow upward.
  - Example: 1000 becomes 0999 when MAX_DIGIT=9.
  - Underflow is impossible, because 0 is only ever reached via the value-equal-to-1 rule.
- Latency: every output is registered and updates on the edge that samples the cause, so it is visible one cycle after the stimulus.
- timeout_pulse: high for exactly one cycle on each transition into EXPIRED, including load of 0. It stays low when a reload of 0 holds the block in EXPIRED.
- warn:
  - Computed from the next-state value, so it is registered together with digits_out.
  - Forced to 0 in IDLE and EXPIRED.
  - The value is interpreted as decimal digits weighted by powers of 10, even when MAX_DIGIT is less than 9.
- Simultaneous events:
  - rst has priority over load, which has priority over the enable/tick transitions.
  - tick arriving in the same cycle that enable rises from PAUSE is ignored; counting starts from the next tick.

Test Plan:
- rst=1 mid-RUN with value 0042 -> next cycle digits_out=0000, running=0, timeout=0, warn=0.
- load 4'hC in digit 0 and 4'hA in digit 2 (load_value=16'h0A0C), enable=1 -> digits_out=16'h0909, running=1.
- Load 1000 with enable=1, one tick -> 0999. Then 989 further ticks -> 0010 with warn=1, which rose when the value became 0010 (WARN_LEVEL=10).
- Load 0002, enable=1, two ticks -> after the second tick digits_out=0000, timeout=1, and timeout_pulse is high for exactly one cycle. Further ticks -> no change.
- AUTO_RELOAD=1, load 0003, run to EXPIRED, one more tick -> digits_out=0003, running=1, timeout=0. Then 3 ticks -> a second timeout_pulse.
- In RUN, drop enable and pulse tick in the same cycle -> value unchanged, state PAUSE. Then assert load=1 and tick=1 together with load_value=0000 -> EXPIRED and timeout_pulse=1.
